// File: rtl/vx_gpu_pkg.sv
// Shared GPU-side definitions used by the LSU memory responder and its interface.
package vx_gpu_pkg;

  localparam int LSU_ATYPE_BITS = 2;

  typedef enum logic [1:0] {
    LSU_MEM_IDLE,
    LSU_MEM_SERVE,
    LSU_MEM_WAIT,
    LSU_MEM_RSP
  } lsu_mem_state_e;

  // Index width that stays at least one bit wide for single-entry structures.
  function automatic int log2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/vx_lsu_mem_if.sv
// LSU memory protocol: one multi-lane request channel, one response channel.
interface vx_lsu_mem_if
  import vx_gpu_pkg::*;
#(
  parameter int NUM_LANES  = 4,
  parameter int DATA_SIZE  = 4,
  parameter int TAG_WIDTH  = 8,
  parameter int ADDR_WIDTH = 32
) ();

  typedef struct packed {
    logic                                          rw;
    logic [NUM_LANES-1:0]                          mask;
    logic [NUM_LANES-1:0][DATA_SIZE-1:0]           byteen;
    logic [NUM_LANES-1:0][ADDR_WIDTH-1:0]          addr;
    logic [NUM_LANES-1:0][LSU_ATYPE_BITS-1:0]      atype;
    logic [NUM_LANES-1:0][DATA_SIZE*8-1:0]         data;
    logic [TAG_WIDTH-1:0]                          tag;
    logic                                          spatial;
    logic                                          cache_sel;
  } req_data_t;

  typedef struct packed {
    logic [NUM_LANES-1:0]                  mask;
    logic [NUM_LANES-1:0][DATA_SIZE*8-1:0] data;
    logic [TAG_WIDTH-1:0]                  tag;
  } rsp_data_t;

  logic      req_valid;
  req_data_t req_data;
  logic      req_ready;
  logic      rsp_valid;
  rsp_data_t rsp_data;
  logic      rsp_ready;

  modport master (
    output req_valid, req_data, rsp_ready,
    input  req_ready, rsp_valid, rsp_data
  );

  modport slave (
    input  req_valid, req_data, rsp_ready,
    output req_ready, rsp_valid, rsp_data
  );

endinterface

// File: rtl/vx_lsu_mem_bank.sv
// Single-port bank RAM: byte-enabled write, registered read with one-cycle latency.
module vx_lsu_mem_bank
  import vx_gpu_pkg::*;
#(
  parameter int DATA_SIZE  = 4,
  parameter int BANK_WORDS = 256,
  localparam int ROW_BITS  = log2_min1(BANK_WORDS)
) (
  input  logic                   clk,
  input  logic                   en,
  input  logic                   we,
  input  logic [DATA_SIZE-1:0]   byteen,
  input  logic [ROW_BITS-1:0]    addr,
  input  logic [DATA_SIZE*8-1:0] wdata,
  output logic [DATA_SIZE*8-1:0] rdata
);

  logic [DATA_SIZE-1:0][7:0] mem [BANK_WORDS];

  // NOTE: the array has no reset branch on purpose; clearing a RAM would need a
  // per-word write port and would stop it from mapping onto block memory.
  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        for (int j = 0; j < DATA_SIZE; j++) begin
          if (byteen[j]) mem[addr][j] <= wdata[j*8 +: 8];
        end
      end
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/vx_lsu_mem_responder.sv
// Banked scratchpad responder for the LSU memory protocol; same-bank lanes serialize in lane order.
module vx_lsu_mem_responder
  import vx_gpu_pkg::*;
#(
  parameter int NUM_LANES  = 4,
  parameter int DATA_SIZE  = 4,
  parameter int TAG_WIDTH  = 8,
  parameter int ADDR_WIDTH = 32,
  parameter int NUM_BANKS  = 4,
  parameter int BANK_WORDS = 256
) (
  input  logic        clk,
  input  logic        reset,
  vx_lsu_mem_if.slave mem_bus_if
);

  localparam int WORD_BITS     = DATA_SIZE * 8;
  localparam int BANK_SEL_BITS = log2_min1(NUM_BANKS);
  localparam int ROW_BITS      = log2_min1(BANK_WORDS);
  localparam int LANE_BITS     = log2_min1(NUM_LANES);

  lsu_mem_state_e state;

  logic                                 req_rw;
  logic [NUM_LANES-1:0]                 req_mask;
  logic [NUM_LANES-1:0][DATA_SIZE-1:0]  req_byteen;
  logic [NUM_LANES-1:0][ADDR_WIDTH-1:0] req_addr;
  logic [NUM_LANES-1:0][WORD_BITS-1:0]  req_wdata;

  logic [NUM_LANES-1:0] pending;
  logic [NUM_LANES-1:0] pending_next;
  logic [NUM_LANES-1:0] lane_grant;

  logic [BANK_SEL_BITS-1:0] lane_bank [NUM_LANES];
  logic [ROW_BITS-1:0]      lane_row  [NUM_LANES];

  logic [NUM_BANKS-1:0] grant_valid;
  logic [LANE_BITS-1:0] grant_lane [NUM_BANKS];

  logic                 bank_en     [NUM_BANKS];
  logic                 bank_we     [NUM_BANKS];
  logic [DATA_SIZE-1:0] bank_byteen [NUM_BANKS];
  logic [ROW_BITS-1:0]  bank_addr   [NUM_BANKS];
  logic [WORD_BITS-1:0] bank_wdata  [NUM_BANKS];
  logic [WORD_BITS-1:0] bank_rdata  [NUM_BANKS];

  logic [NUM_BANKS-1:0] rd_vld;
  logic [LANE_BITS-1:0] rd_lane [NUM_BANKS];

  logic                                rsp_valid;
  logic [NUM_LANES-1:0]                rsp_mask;
  logic [NUM_LANES-1:0][WORD_BITS-1:0] rsp_lane_data;
  logic [TAG_WIDTH-1:0]                rsp_tag;

  logic unused_req_fields;
  assign unused_req_fields = ^{mem_bus_if.req_data.atype, mem_bus_if.req_data.spatial,
                               mem_bus_if.req_data.cache_sel};

  // Power-of-two bank count makes the modulo/divide plain bit slices; upper bits wrap away.
  always_comb begin
    for (int i = 0; i < NUM_LANES; i++) begin
      lane_bank[i] = BANK_SEL_BITS'(req_addr[i] % ADDR_WIDTH'(NUM_BANKS));
      lane_row[i]  = ROW_BITS'(req_addr[i] / ADDR_WIDTH'(NUM_BANKS));
    end
  end

  // NOTE: every output of this block gets a default before the loops, so no path
  // leaves a value held over from the last evaluation and no latch is inferred.
  always_comb begin
    grant_valid = '0;
    grant_lane  = '{default: '0};
    lane_grant  = '0;
    for (int b = 0; b < NUM_BANKS; b++) begin
      for (int i = 0; i < NUM_LANES; i++) begin
        if (!grant_valid[b] && pending[i] && lane_bank[i] == BANK_SEL_BITS'(b)) begin
          grant_valid[b] = 1'b1;
          grant_lane[b]  = LANE_BITS'(i);
          lane_grant[i]  = 1'b1;
        end
      end
    end
  end

  assign pending_next = pending & ~lane_grant;

  // A bank access in the reset cycle is suppressed so a dropped write cannot land late.
  always_comb begin
    bank_en     = '{default: '0};
    bank_we     = '{default: '0};
    bank_byteen = '{default: '0};
    bank_addr   = '{default: '0};
    bank_wdata  = '{default: '0};
    for (int b = 0; b < NUM_BANKS; b++) begin
      bank_en[b]     = !reset && (state == LSU_MEM_SERVE) && grant_valid[b];
      bank_we[b]     = req_rw;
      bank_byteen[b] = req_byteen[grant_lane[b]];
      bank_addr[b]   = lane_row[grant_lane[b]];
      bank_wdata[b]  = req_wdata[grant_lane[b]];
    end
  end

  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    vx_lsu_mem_bank #(
      .DATA_SIZE  (DATA_SIZE),
      .BANK_WORDS (BANK_WORDS)
    ) u_bank (
      .clk    (clk),
      .en     (bank_en[b]),
      .we     (bank_we[b]),
      .byteen (bank_byteen[b]),
      .addr   (bank_addr[b]),
      .wdata  (bank_wdata[b]),
      .rdata  (bank_rdata[b])
    );
  end

  // NOTE: all state here is updated with <= so every register sees the
  // pre-edge values of its neighbours, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= LSU_MEM_IDLE;
      pending       <= '0;
      req_rw        <= 1'b0;
      req_mask      <= '0;
      req_byteen    <= '0;
      req_addr      <= '0;
      req_wdata     <= '0;
      rd_vld        <= '0;
      rd_lane       <= '{default: '0};
      rsp_valid     <= 1'b0;
      rsp_mask      <= '0;
      rsp_lane_data <= '0;
      rsp_tag       <= '0;
    end else begin
      rd_vld  <= (state == LSU_MEM_SERVE && !req_rw) ? grant_valid : '0;
      rd_lane <= grant_lane;

      case (state)
        LSU_MEM_IDLE: begin
          if (mem_bus_if.req_valid) begin
            req_rw        <= mem_bus_if.req_data.rw;
            req_mask      <= mem_bus_if.req_data.mask;
            req_byteen    <= mem_bus_if.req_data.byteen;
            req_addr      <= mem_bus_if.req_data.addr;
            req_wdata     <= mem_bus_if.req_data.data;
            pending       <= mem_bus_if.req_data.mask;
            rsp_mask      <= mem_bus_if.req_data.mask;
            rsp_tag       <= mem_bus_if.req_data.tag;
            rsp_lane_data <= '0;
            state         <= LSU_MEM_SERVE;
          end
        end
        LSU_MEM_SERVE: begin
          pending <= pending_next;
          if (pending_next == '0) state <= req_rw ? LSU_MEM_IDLE : LSU_MEM_WAIT;
        end
        LSU_MEM_WAIT: begin
          rsp_valid <= 1'b1;
          state     <= LSU_MEM_RSP;
        end
        LSU_MEM_RSP: begin
          if (mem_bus_if.rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= LSU_MEM_IDLE;
          end
        end
        default: state <= LSU_MEM_IDLE;
      endcase

      // Read data arrives one cycle after its grant; route it back to the granting lane.
      for (int b = 0; b < NUM_BANKS; b++) begin
        if (rd_vld[b]) rsp_lane_data[rd_lane[b]] <= bank_rdata[b];
      end
    end
  end

  assign mem_bus_if.req_ready = (state == LSU_MEM_IDLE) && !reset;
  assign mem_bus_if.rsp_valid = rsp_valid;
  assign mem_bus_if.rsp_data  = {rsp_mask, rsp_lane_data, rsp_tag};

endmodule

// File: tb/tb_vx_lsu_mem_responder.sv
// Randomized self-checking bench for vx_lsu_mem_responder against a flat-memory reference model.
module tb_vx_lsu_mem_responder;

  localparam int NL = 4, DS = 4, TW = 8, AW = 32, NB = 4, BW = 256;
  localparam int MEM_WORDS = NB * BW;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  vx_lsu_mem_if #(.NUM_LANES(NL), .DATA_SIZE(DS), .TAG_WIDTH(TW), .ADDR_WIDTH(AW)) mem_bus_if ();

  vx_lsu_mem_responder #(
    .NUM_LANES(NL), .DATA_SIZE(DS), .TAG_WIDTH(TW), .ADDR_WIDTH(AW),
    .NUM_BANKS(NB), .BANK_WORDS(BW)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .mem_bus_if (mem_bus_if)
  );

  int total = 0;
  int bad   = 0;

  logic [31:0] ref_mem [MEM_WORDS];

  logic             r_rw;
  logic [3:0]       r_mask;
  logic [3:0][3:0]  r_be;
  logic [3:0][31:0] r_addr;
  logic [3:0][31:0] r_data;
  logic [7:0]       r_tag;

  int               cur_k;
  logic [3:0][31:0] exp_data;
  logic [3:0]       exp_mask;
  logic [7:0]       exp_tag;

  task automatic check(input string tag, input logic [159:0] got, input logic [159:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic set_req(input logic rw, input logic [3:0] mask, input logic [15:0] be,
                         input logic [127:0] addr, input logic [127:0] data, input logic [7:0] tag);
    r_rw = rw; r_mask = mask; r_be = be; r_addr = addr; r_data = data; r_tag = tag;
  endtask

  task automatic drive_req();
    mem_bus_if.req_data           = '0;
    mem_bus_if.req_data.rw        = r_rw;
    mem_bus_if.req_data.mask      = r_mask;
    mem_bus_if.req_data.byteen    = r_be;
    mem_bus_if.req_data.addr      = r_addr;
    mem_bus_if.req_data.data      = r_data;
    mem_bus_if.req_data.tag       = r_tag;
    mem_bus_if.req_data.atype     = 8'($urandom);
    mem_bus_if.req_data.spatial   = 1'($urandom);
    mem_bus_if.req_data.cache_sel = 1'($urandom);
    mem_bus_if.req_valid          = 1'b1;
  endtask

  // Reference: a flat word memory indexed by address modulo capacity; lanes apply in index order.
  task automatic model_accept();
    int cnt [NB];
    int idx;
    for (int b = 0; b < NB; b++) cnt[b] = 0;
    cur_k = 1;
    for (int i = 0; i < NL; i++) begin
      if (r_mask[i]) begin
        cnt[r_addr[i] % NB]++;
        if (cnt[r_addr[i] % NB] > cur_k) cur_k = cnt[r_addr[i] % NB];
      end
    end
    exp_mask = r_mask;
    exp_tag  = r_tag;
    for (int i = 0; i < NL; i++) begin
      idx = int'(r_addr[i] % MEM_WORDS);
      if (r_rw && r_mask[i]) begin
        for (int j = 0; j < DS; j++) begin
          if (r_be[i][j]) ref_mem[idx][j*8 +: 8] = r_data[i][j*8 +: 8];
        end
      end
      exp_data[i] = (!r_rw && r_mask[i]) ? ref_mem[idx] : 32'h0;
    end
  endtask

  // Called on a falling edge; returns on the falling edge right after the accept edge.
  task automatic issue();
    int w = 0;
    drive_req();
    while (!mem_bus_if.req_ready && w < 100) begin
      @(negedge clk);
      w++;
    end
    if (w >= 100) begin
      check("req_ready_timeout", 0, 1);
      mem_bus_if.req_valid = 1'b0;
      return;
    end
    @(posedge clk);
    @(negedge clk);
    mem_bus_if.req_valid = 1'b0;
    model_accept();
  endtask

  task automatic wait_rsp_valid(input string tag);
    int n = 0;
    while (!mem_bus_if.rsp_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) begin
      check({tag, "_timeout"}, 0, 1);
    end else begin
      check({tag, "_lat"}, n, cur_k + 1);
      check({tag, "_data"}, mem_bus_if.rsp_data.data, exp_data);
      check({tag, "_mask"}, mem_bus_if.rsp_data.mask, exp_mask);
      check({tag, "_tag"}, mem_bus_if.rsp_data.tag, exp_tag);
    end
  endtask

  task automatic finish_read(input string tag);
    wait_rsp_valid(tag);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic finish_write(input string tag);
    int n = 0;
    while (!mem_bus_if.req_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) check({tag, "_timeout"}, 0, 1);
    else          check({tag, "_lat"}, n, cur_k);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int seen;
    reset                = 1'b1;
    mem_bus_if.req_valid = 1'b0;
    mem_bus_if.req_data  = '0;
    mem_bus_if.rsp_ready = 1'b1;
    for (int i = 0; i < MEM_WORDS; i++) ref_mem[i] = 32'h0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_req_ready", mem_bus_if.req_ready, 0);
    check("rst_rsp_valid", mem_bus_if.rsp_valid, 0);
    check("rst_rsp_data", mem_bus_if.rsp_data, 0);
    reset = 1'b0;
    #1;
    check("rst_release_ready", mem_bus_if.req_ready, 1);
    @(negedge clk);

    // Fill every word so later reads compare against known contents.
    for (int w = 0; w < MEM_WORDS / NL; w++) begin
      set_req(1'b1, 4'hF, 16'hFFFF,
              {32'(4*w+3), 32'(4*w+2), 32'(4*w+1), 32'(4*w)},
              {$urandom, $urandom, $urandom, $urandom}, 8'h00);
      issue();
      finish_write("init_wr");
    end

    set_req(1'b1, 4'hF, 16'hFFFF, {32'd3, 32'd2, 32'd1, 32'd0},
            {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111}, 8'h00);
    issue();
    finish_write("cf_wr");
    set_req(1'b0, 4'hF, 16'h0, {32'd3, 32'd2, 32'd1, 32'd0}, 128'h0, 8'h5A);
    issue();
    finish_read("cf_rd");
    check("cf_rd_const", mem_bus_if.rsp_data.data,
          128'h44444444_33333333_22222222_11111111);

    set_req(1'b0, 4'hF, 16'h0, {32'd12, 32'd8, 32'd4, 32'd0}, 128'h0, 8'hC4);
    issue();
    finish_read("conflict4_rd");

    set_req(1'b1, 4'b0101, 16'h010F, {32'd5, 32'd5, 32'd5, 32'd5},
            {32'h0, 32'h000000EE, 32'h0, 32'hAABBCCDD}, 8'h00);
    issue();
    finish_write("same_addr_wr");
    set_req(1'b0, 4'b0001, 16'h0, {32'd0, 32'd0, 32'd0, 32'd5}, 128'h0, 8'h21);
    issue();
    finish_read("same_addr_rd");
    check("same_addr_const", mem_bus_if.rsp_data.data[0], 32'hAABBCCEE);

    set_req(1'b0, 4'b0101, 16'h0, {32'd7, 32'd6, 32'd9, 32'd8}, 128'h0, 8'h77);
    issue();
    finish_read("mask5_rd");
    check("mask5_lane1_zero", mem_bus_if.rsp_data.data[1], 32'h0);
    check("mask5_lane3_zero", mem_bus_if.rsp_data.data[3], 32'h0);
    set_req(1'b0, 4'b0000, 16'h0, {32'd3, 32'd2, 32'd1, 32'd0}, 128'h0, 8'h33);
    issue();
    finish_read("mask0_rd");

    // Backpressure: response held for five cycles while a write waits at the request port.
    mem_bus_if.rsp_ready = 1'b0;
    set_req(1'b0, 4'hF, 16'h0, {32'd11, 32'd10, 32'd9, 32'd8}, 128'h0, 8'hB0);
    issue();
    wait_rsp_valid("bp_rd");
    set_req(1'b1, 4'hF, 16'hFFFF, {32'd23, 32'd22, 32'd21, 32'd20},
            {$urandom, $urandom, $urandom, $urandom}, 8'h00);
    drive_req();
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check("bp_rsp_valid_held", mem_bus_if.rsp_valid, 1);
      check("bp_rsp_data_stable", mem_bus_if.rsp_data, {exp_mask, exp_data, exp_tag});
      check("bp_req_ready_low", mem_bus_if.req_ready, 0);
    end
    mem_bus_if.rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("bp_rsp_valid_drop", mem_bus_if.rsp_valid, 0);
    check("bp_req_ready_after_hs", mem_bus_if.req_ready, 1);
    @(posedge clk);
    @(negedge clk);
    mem_bus_if.req_valid = 1'b0;
    model_accept();
    finish_write("bp_wr");
    set_req(1'b0, 4'hF, 16'h0, {32'd23, 32'd22, 32'd21, 32'd20}, 128'h0, 8'hB1);
    issue();
    finish_read("bp_readback");

    for (int n = 0; n < 60; n++) begin
      logic [127:0] a;
      for (int i = 0; i < NL; i++)
        a[i*32 +: 32] = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 15));
      set_req(1'($urandom), 4'($urandom), 16'($urandom), a,
              {$urandom, $urandom, $urandom, $urandom}, 8'($urandom));
      issue();
      if (r_rw) finish_write("rand_wr");
      else      finish_read("rand_rd");
    end

    // Reset in the second cycle of a four-way conflicting read.
    set_req(1'b0, 4'hF, 16'h0, {32'd13, 32'd9, 32'd5, 32'd1}, 128'h0, 8'hEE);
    issue();
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("mid_rst_req_ready", mem_bus_if.req_ready, 0);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("mid_rst_rsp_data", mem_bus_if.rsp_data, 0);
    check("mid_rst_req_ready_after", mem_bus_if.req_ready, 1);
    seen = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (mem_bus_if.rsp_valid) seen++;
    end
    check("mid_rst_no_rsp", seen, 0);
    issue();
    finish_read("post_rst_rd");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/vx_lsu_mem_responder.md
# VX_lsu_mem_responder

Slave-side endpoint of the `VX_lsu_mem_if` LSU memory protocol: a banked, byte-enabled local memory that accepts one multi-lane request at a time and returns one response per read request. Each lane's word address selects a bank. Lanes that target the same bank are serialized in lane-index order. The block sits wherever an LSU master needs a private scratchpad target, and serves as the reference responder for LSU-side verification.

## Interface
- `NUM_LANES`, 4, lanes per request
- `DATA_SIZE`, 4, bytes per lane word
- `TAG_WIDTH`, 8, opaque request tag, returned unchanged
- `ADDR_WIDTH`, 32, word-address width per lane
- `NUM_BANKS`, 4, power of two, ≥1
- `BANK_WORDS`, 256, power of two, words per bank
- `clk`  in  1  clock
- `reset`  in  1  synchronous, active-high
- `mem_bus_if`  `VX_lsu_mem_if.slave`  `#(NUM_LANES, DATA_SIZE, TAG_WIDTH, ADDR_WIDTH)`  request in, response out
  - `atype`, `spatial` and `cache_sel` are ignored.

## Operation
- Request handshake: a request is accepted when `req_valid && req_ready`. The accepted `rw`, `mask`, `byteen`, `addr`, `data` and `tag` are latched.
- `req_ready` = (state == IDLE).
- Lane mapping:
  - bank = `addr[i][log2(NUM_BANKS)-1:0]`
  - row = next `log2(BANK_WORDS)` bits
  - higher address bits are ignored, so addresses wrap.
- FSM: IDLE → SERVE → WAIT → RSP → IDLE.
  - IDLE: waits for a handshake; on accept goes to SERVE.
  - SERVE: each cycle, each bank grants the lowest-index pending lane (mask bit set, not yet served) that maps to it. Granted lanes are cleared from the pending set. The FSM leaves SERVE after the cycle in which the pending set becomes empty. A zero-mask request spends exactly one SERVE cycle with no grants.
  - From SERVE: a write returns to IDLE; a read goes to WAIT.
  - WAIT: one cycle, captures the read data of the final grants.
  - RSP: `rsp_valid`=1 and holds until `rsp_ready`; then the FSM returns to IDLE.
- Writes:
  - Each granted lane writes the bytes selected by `byteen[i]` in its SERVE cycle.
  - Writes produce no response.
  - Same-address lanes serialize, so the highest-index lane's bytes win.
- Reads:
  - Bank read data for a grant in cycle c is valid in c+1 and is stored into response lane i at the end of c+1.
  - `rsp_data.mask` = request mask.
  - `rsp_data.tag` = request tag.
  - Unmasked lanes return 0.
- Response: `rsp_data` is stable while `rsp_valid && !rsp_ready`.
- Storage: memory contents are not initialized and are not cleared by reset.

## Timing
- Reset values: state IDLE, `req_ready`=0 during reset and 1 the cycle after, `rsp_valid`=0, `rsp_data`=0, pending set cleared.
- Let K = max(1, max over banks of active lanes mapped to that bank).
- Read accepted in cycle T: SERVE occupies T+1..T+K, WAIT is T+K+1, `rsp_valid` rises at T+K+2. A conflict-free read gives `rsp_valid` at T+3.
- Write accepted in cycle T: last byte write occurs at T+K. `req_ready` is 1 again at T+K+1.
- Throughput: one outstanding request. No new request is accepted while a response is held.
- Reset mid-operation: the in-flight request is dropped with no response. Partial writes already committed remain.
- `rsp_ready` held low indefinitely: the FSM stays in RSP and `req_ready` stays 0.

## Structure
- `VX_lsu_mem_bank` is the only sub-module: a single-port RAM of `BANK_WORDS`×`DATA_SIZE` bytes with byte-enabled write and registered read (1-cycle latency). It is instantiated `NUM_BANKS` times.
- Bank-select and row-extract bit widths are localparams computed from the parameters.
- The state enum belongs in `VX_gpu_pkg`. Request and response structs come from the interface.
- Per-bank grant: a priority encoder over lanes that are pending and match the bank. This is combinational in the top module.

## Test plan
- Conflict-free write then read:
  - Stimulus: write lanes 0..3 at addrs 0,1,2,3 with data 0x11111111..0x44444444 and full `byteen`; then read the same addresses with tag 0x5A.
  - Required: `rsp_valid` 3 cycles after read accept; data 0x11111111..0x44444444; mask 0xF; tag 0x5A.
- Full bank conflict:
  - Stimulus: read addrs 0,4,8,12 (all bank 0).
  - Required: 4 SERVE cycles; `rsp_valid` at T+6; correct data in each lane.
- Byte enable and same-address write:
  - Stimulus: lanes 0 and 2 write addr 5. Lane 0 writes data 0xAABBCCDD with `byteen` 0xF; lane 2 writes data 0x000000EE with `byteen` 0x1.
  - Required: read of addr 5 returns 0xAABBCCEE.
- Partial and zero mask:
  - Stimulus: read with mask 0x5; then read with mask 0x0 and tag 0x33.
  - Required: lanes 1 and 3 return 0 on the first read. The zero-mask read gives `rsp_valid` at T+3 with mask 0 and tag 0x33.
- Backpressure:
  - Stimulus: hold `rsp_ready`=0 for 5 cycles, with a second request valid throughout.
  - Required: `rsp_data` stable, `req_ready`=0; the second request is accepted the cycle after the response handshake.
- Reset mid-SERVE:
  - Stimulus: assert `reset` during a 4-way-conflict read.
  - Required: no response is ever issued; `req_ready`=1 one cycle after reset deasserts.
